// File: rtl/sim_select_pkg.sv
// ============================================================================
// Module      : sim_select_pkg
// Description : Shared types, FP16 constants and helpers for the selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sim_select_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [15:0] FP16_NEG_INF  = 16'hFC00;
    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;

    function automatic logic fp16_is_nan(input logic [15:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp16_compare.sv
// ============================================================================
// Module      : fp16_compare
// Description : Combinational FP16 ordering compare (a > b, a >= b); NaN is
//               not handled here and must be masked by the caller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp16_compare (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        gt,
    output logic        ge
);

    logic [15:0] w_key_a;
    logic [15:0] w_key_b;

    // Maps sign-magnitude onto an unsigned total order; both zeros share a key.
    function automatic logic [15:0] order_key(input logic [15:0] v);
        if (v[14:0] == 15'd0) begin
            return 16'h8000;
        end else if (v[15]) begin
            return ~v;
        end else begin
            return v | 16'h8000;
        end
    endfunction

    assign w_key_a = order_key(a);
    assign w_key_b = order_key(b);
    assign gt      = (w_key_a >  w_key_b);
    assign ge      = (w_key_a >= w_key_b);

endmodule

`default_nettype wire

// File: rtl/similarity_match_selector.sv
// ============================================================================
// Module      : similarity_match_selector
// Description : Picks the best-scoring of NUM_CAND FP16 similarity results and
//               flags whether it meets a threshold. Optional macro
//               SIM_SELECT_STATS_EN adds the above_count statistic port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module similarity_match_selector
    import sim_select_pkg::*;
#(
    parameter int NUM_CAND = 16,
    parameter int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      threshold,
    input  logic             sim_valid,
    input  logic [15:0]      sim_in,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] best_idx,
    output logic [15:0]      best_sim,
    output logic             match_found
`ifdef SIM_SELECT_STATS_EN
    ,
    output logic [IDX_W:0]   above_count
`endif
);

    localparam logic [IDX_W:0] C_LAST_CNT = (IDX_W+1)'(NUM_CAND - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W:0]   r_cand_cnt;
    logic [15:0]      r_run_sim;
    logic [IDX_W-1:0] r_run_idx;
    logic [15:0]      r_thr;
    logic             r_any_above;

    logic             w_accept;
    logic             w_last;
    logic             w_num;
    logic             w_gt_best;
    logic             w_ge_best_unused;
    logic             w_gt_thr_unused;
    logic             w_ge_thr;
    logic             w_above_now;
    logic [15:0]      w_next_sim;
    logic [IDX_W-1:0] w_next_idx;

    // start always wins over a coincident sample
    assign w_accept    = (r_state == S_COLLECT) && sim_valid && !start;
    assign w_last      = w_accept && (r_cand_cnt == C_LAST_CNT);
    assign w_num       = !fp16_is_nan(sim_in);
    assign w_above_now = w_accept && w_num && w_ge_thr;

    fp16_compare u_cmp_best (
        .a  (sim_in),
        .b  (r_run_sim),
        .gt (w_gt_best),
        .ge (w_ge_best_unused)
    );

    fp16_compare u_cmp_thr (
        .a  (sim_in),
        .b  (r_thr),
        .gt (w_gt_thr_unused),
        .ge (w_ge_thr)
    );

    always_comb begin
        w_next_sim = r_run_sim;
        w_next_idx = r_run_idx;
        if (w_accept && w_num && w_gt_best) begin
            w_next_sim = sim_in;
            w_next_idx = r_cand_cnt[IDX_W-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_COLLECT;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_IDLE;
                S_COLLECT: if (w_last) w_state_nxt = S_DONE;
                S_DONE:    w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= (w_state_nxt == S_COLLECT);
            done    <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand_cnt  <= '0;
            r_run_sim   <= FP16_NEG_INF;
            r_run_idx   <= '0;
            r_thr       <= FP16_POS_ZERO;
            r_any_above <= 1'b0;
            best_idx    <= '0;
            best_sim    <= FP16_POS_ZERO;
            match_found <= 1'b0;
        end else if (start) begin
            r_cand_cnt  <= '0;
            r_run_sim   <= FP16_NEG_INF;
            r_run_idx   <= '0;
            r_thr       <= threshold;
            r_any_above <= 1'b0;
            best_idx    <= '0;
            best_sim    <= FP16_POS_ZERO;
            match_found <= 1'b0;
        end else if (w_accept) begin
            r_cand_cnt  <= r_cand_cnt + 1'b1;
            r_run_sim   <= w_next_sim;
            r_run_idx   <= w_next_idx;
            r_any_above <= r_any_above | w_above_now;
            // best >= threshold exactly when some non-NaN sample reached it
            if (w_last) begin
                best_sim    <= w_next_sim;
                best_idx    <= w_next_idx;
                match_found <= r_any_above | w_above_now;
            end
        end
    end

`ifdef SIM_SELECT_STATS_EN
    logic [IDX_W:0] r_above_cnt;
    logic [IDX_W:0] w_above_cnt_nxt;

    assign w_above_cnt_nxt = (w_above_now && (r_above_cnt != (IDX_W+1)'(NUM_CAND)))
                           ? r_above_cnt + 1'b1 : r_above_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_above_cnt <= '0;
            above_count <= '0;
        end else if (start) begin
            r_above_cnt <= '0;
            above_count <= '0;
        end else if (w_accept) begin
            r_above_cnt <= w_above_cnt_nxt;
            if (w_last) begin
                above_count <= w_above_cnt_nxt;
            end
        end
    end
`endif

endmodule

`default_nettype wire
